rate_switch_sched: RTL and testbench

Round-robin scheduler that shares one `Rate_Switch` buffer among several requesters in the `output_clk` domain. Each requester asks for a burst of N points. The block picks one requester, drives `start_sig`/`piont_num` into the buffer, and tracks the burst through `data_vaild`/`data_tlast`. It then returns completion or error to the granted requester before serving the next one.

---
 rtl/rate_switch_sched_pkg.sv | 21 ++
 rtl/rate_switch_sched_rr_arbiter.sv | 30 +++
 rtl/rate_switch_sched.sv | 146 ++++++++++++++
 tb/tb_rate_switch_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rate_switch_sched_pkg.sv
// Shared types and constants for the Rate_Switch buffer scheduler.
package rate_switch_sched_pkg;

  localparam int unsigned LEN_W   = 16;
  localparam int unsigned MIN_LEN = 8;
  localparam int unsigned CNT_W   = 17;
  localparam int unsigned TO_W    = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_t;

  // The buffer cannot produce bursts shorter than MIN_LEN points.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len < LEN_W'(MIN_LEN)) ? LEN_W'(MIN_LEN) : len;
  endfunction

endpackage

// File: rtl/rate_switch_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, wrapping.
module rr_arbiter
  import rate_switch_sched_pkg::*;
#(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] rr_ptr,
  output logic [N_CH-1:0]         pick,
  output logic                    any
);

  localparam int unsigned PTR_W = $clog2(N_CH);

  logic [PTR_W-1:0] w_idx;

  always_comb begin
    pick  = '0;
    any   = 1'b0;
    w_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      w_idx = PTR_W'((32'(rr_ptr) + i) % N_CH);
      if (!any && req[w_idx]) begin
        pick[w_idx] = 1'b1;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rate_switch_sched.sv
// Round-robin scheduler sharing one Rate_Switch buffer among N_CH requesters.
// Define RS_SCHED_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT cycles).
module rate_switch_sched
  import rate_switch_sched_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned START_HOLD = 8,
  parameter int unsigned GAP        = 4,
  parameter int unsigned TIMEOUT    = 1048576
) (
  input  logic                  output_clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       req,
  input  logic [N_CH*LEN_W-1:0] req_len,
  output logic [N_CH-1:0]       grant,
  output logic [N_CH-1:0]       done,
  output logic                  err,
  output logic                  start_sig,
  output logic [LEN_W-1:0]      piont_num,
  input  logic                  data_vaild,
  input  logic                  data_tlast,
  output logic                  busy
);

  localparam int unsigned PTR_W  = $clog2(N_CH);
  localparam int unsigned HOLD_W = $clog2(START_HOLD + 1);

  if (N_CH < 2 || N_CH > 8 || GAP < 1 || GAP > 255 || START_HOLD < 1 ||
      TIMEOUT < 1 || TIMEOUT >= (1 << TO_W)) begin : g_cfg_err
    $error("rate_switch_sched: parameter out of range");
  end

  sched_state_t      r_state, w_next_state;
  logic [N_CH-1:0]   w_pick, r_grant, r_done;
  logic              w_any, r_err, r_start;
  logic [PTR_W-1:0]  w_pick_ch, r_ch, r_rr_ptr, w_next_ptr;
  logic [LEN_W-1:0]  r_piont_num;
  logic [CNT_W-1:0]  r_beat_cnt, w_beats;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [7:0]        r_gap_cnt;
  logic              w_hold_done, w_gap_done, w_good, w_timeout, w_burst_end;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .pick   (w_pick),
    .any    (w_any)
  );

  always_comb begin
    w_pick_ch = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (w_pick[i]) w_pick_ch = PTR_W'(i);
    end
  end

`ifdef RS_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge output_clk or negedge rst_n) begin
    if (!rst_n)                  r_to_cnt <= '0;
    else if (r_state != ST_WAIT) r_to_cnt <= '0;
    else                         r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == ST_WAIT) && (r_to_cnt == TO_W'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Beat count including the current cycle; decides done vs err on tlast.
  assign w_beats     = (data_vaild && (r_beat_cnt != '1)) ? r_beat_cnt + 1'b1 : r_beat_cnt;
  assign w_good      = (w_beats == {1'b0, r_piont_num});
  assign w_hold_done = (r_hold_cnt == HOLD_W'(START_HOLD));
  assign w_gap_done  = (r_gap_cnt == 8'(GAP - 1));
  assign w_burst_end = (r_state == ST_WAIT) && (data_tlast || w_timeout);
  assign w_next_ptr  = (r_ch == PTR_W'(N_CH - 1)) ? '0 : r_ch + 1'b1;

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any)       w_next_state = ST_START;
      ST_START: if (w_hold_done) w_next_state = ST_WAIT;
      ST_WAIT:  if (w_burst_end) w_next_state = ST_GAP;
      ST_GAP:   if (w_gap_done)  w_next_state = ST_IDLE;
      default:                   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge output_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge output_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= 1'b0;
      r_start     <= 1'b0;
      r_ch        <= '0;
      r_rr_ptr    <= '0;
      r_piont_num <= '0;
      r_beat_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_done  <= '0;
      r_err   <= 1'b0;
      // START lasts START_HOLD+1 cycles so start_sig trails grant by one cycle.
      r_start <= (r_state == ST_START) && !w_hold_done;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant     <= w_pick;
            r_ch        <= w_pick_ch;
            r_piont_num <= clamp_len(req_len[32'(w_pick_ch)*LEN_W +: LEN_W]);
            r_beat_cnt  <= '0;
            r_hold_cnt  <= '0;
          end
        end
        ST_START: r_hold_cnt <= r_hold_cnt + 1'b1;
        ST_WAIT: begin
          r_beat_cnt <= w_beats;
          if (w_burst_end) begin
            if (data_tlast && w_good) r_done <= r_grant;
            else                      r_err  <= 1'b1;
            r_grant   <= '0;
            r_rr_ptr  <= w_next_ptr;
            r_gap_cnt <= '0;
          end
        end
        ST_GAP:  r_gap_cnt <= r_gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  assign grant     = r_grant;
  assign done      = r_done;
  assign err       = r_err;
  assign start_sig = r_start;
  assign piont_num = r_piont_num;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rate_switch_sched.sv
// Directed scoreboard bench for rate_switch_sched; timeout case under RS_SCHED_TIMEOUT_EN.
module tb_rate_switch_sched;

  localparam int N_CH       = 4;
  localparam int START_HOLD = 8;
  localparam int GAP        = 4;
`ifdef RS_SCHED_TIMEOUT_EN
  localparam int TO_P = 64;
`else
  localparam int TO_P = 1048576;
`endif

  typedef struct {
    int ch;
    int len;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_CH-1:0]   req = '0;
  logic [N_CH*16-1:0] req_len = '0;
  logic [N_CH-1:0]   grant, done;
  logic              err, start_sig, busy;
  logic [15:0]       piont_num;
  logic              data_vaild = 1'b0;
  logic              data_tlast = 1'b0;

  rate_switch_sched #(
    .N_CH       (N_CH),
    .START_HOLD (START_HOLD),
    .GAP        (GAP),
    .TIMEOUT    (TO_P)
  ) dut (
    .output_clk (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_len    (req_len),
    .grant      (grant),
    .done       (done),
    .err        (err),
    .start_sig  (start_sig),
    .piont_num  (piont_num),
    .data_vaild (data_vaild),
    .data_tlast (data_tlast),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  int   last_end = 0;
  exp_t exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic int clamp8(input int l);
    return (l < 8) ? 8 : l;
  endfunction

  task automatic set_len(input int ch, input int len);
    req_len[16*ch +: 16] = 16'(len);
  endtask

  task automatic push(input int ch, input int len);
    exp_q.push_back('{ch, clamp8(len)});
  endtask

  task automatic wait_grant(input string tag, input bit chk_sep, output exp_t e, output bit ok);
    int n;
    n = 0;
    e = '{0, 0};
    while (grant == '0 && n < 60) begin
      tick();
      n++;
    end
    ok = (grant != '0) && (exp_q.size() > 0);
    check({tag, ":grant_arrives"}, 32'(ok), 1);
    if (ok) begin
      e = exp_q.pop_front();
      check({tag, ":grant"}, 32'(grant), 32'(1 << e.ch));
      check({tag, ":piont_num"}, 32'(piont_num), 32'(e.len));
      check({tag, ":busy"}, 32'(busy), 1);
      check({tag, ":start_at_grant"}, 32'(start_sig), 0);
      if (chk_sep) check({tag, ":gap_sep"}, 32'(cyc - last_end), 32'(GAP + 1));
    end
  endtask

  task automatic count_start(input string tag, input bit inj_tlast);
    int hi;
    tick();
    hi = 0;
    while (start_sig === 1'b1 && hi < 100) begin
      data_tlast = inj_tlast && (hi == 2);
      data_vaild = inj_tlast && (hi == 2);
      hi++;
      tick();
    end
    data_tlast = 1'b0;
    data_vaild = 1'b0;
    check({tag, ":start_hold"}, 32'(hi), 32'(START_HOLD));
  endtask

  task automatic finish_burst(input string tag, input exp_t e, input int beats);
    bit good;
    for (int b = 0; b < beats; b++) begin
      if (b % 5 == 2) begin
        data_vaild = 1'b0;
        data_tlast = 1'b0;
        tick();
      end
      data_vaild = 1'b1;
      data_tlast = (b == beats - 1);
      tick();
    end
    data_vaild = 1'b0;
    data_tlast = 1'b0;
    good = (beats == e.len);
    check({tag, ":done"}, 32'(done), good ? 32'(1 << e.ch) : 32'd0);
    check({tag, ":err"}, 32'(err), good ? 32'd0 : 32'd1);
    check({tag, ":grant_drop"}, 32'(grant), 0);
    check({tag, ":busy_gap"}, 32'(busy), 1);
    last_end = cyc;
    // stray buffer handshake during GAP must be ignored
    data_vaild = 1'b1;
    data_tlast = 1'b1;
    tick();
    data_vaild = 1'b0;
    data_tlast = 1'b0;
    check({tag, ":done_once"}, 32'(done), 0);
    check({tag, ":err_once"}, 32'(err), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ":grant"}, 32'(grant), 0);
    check({tag, ":done"}, 32'(done), 0);
    check({tag, ":err"}, 32'(err), 0);
    check({tag, ":start"}, 32'(start_sig), 0);
    check({tag, ":piont_num"}, 32'(piont_num), 0);
    check({tag, ":busy"}, 32'(busy), 0);
  endtask

  initial begin
    exp_t e;
    bit   ok;
    int   n;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // round robin with all four requests held; ch1 length clamps to 8
    set_len(0, 10); set_len(1, 3); set_len(2, 20); set_len(3, 12);
    push(0, 10); push(1, 3); push(2, 20); push(3, 12); push(0, 10);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant($sformatf("rr%0d", k), k > 0, e, ok);
      if (ok) begin
        count_start($sformatf("rr%0d", k), 1'b0);
        finish_burst($sformatf("rr%0d", k), e, e.len);
      end
    end
    req = '0;

    // single channel, 100 points
    set_len(1, 100);
    push(1, 100);
    req = 4'b0010;
    wait_grant("single", 1'b0, e, ok);
    if (ok) begin
      count_start("single", 1'b0);
      finish_burst("single", e, 100);
    end
    req = '0;

    // length mismatch on ch3, then pointer must have moved past ch3 to ch0
    set_len(3, 20);
    push(3, 20);
    req = 4'b1000;
    wait_grant("mismatch", 1'b0, e, ok);
    if (ok) begin
      count_start("mismatch", 1'b0);
      finish_burst("mismatch", e, 19);
    end
    set_len(0, 9);
    push(0, 9);
    req = 4'b1001;
    wait_grant("after_err", 1'b0, e, ok);
    if (ok) begin
      count_start("after_err", 1'b0);
      finish_burst("after_err", e, 9);
    end
    req = '0;

    // ch2 burst leaves rr_ptr at 3
    set_len(2, 8);
    push(2, 8);
    req = 4'b0100;
    wait_grant("ch2", 1'b0, e, ok);
    if (ok) begin
      count_start("ch2", 1'b0);
      finish_burst("ch2", e, 8);
    end
    req = '0;

    // asynchronous reset mid-WAIT on a ch0 burst
    set_len(0, 50);
    push(0, 50);
    req = 4'b0001;
    wait_grant("rst_burst", 1'b0, e, ok);
    if (ok) count_start("rst_burst", 1'b0);
    data_vaild = 1'b1;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    data_vaild = 1'b0;
    req = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // rr_ptr back at 0: ch2 wins over ch3
    set_len(2, 16); set_len(3, 16);
    push(2, 16);
    req = 4'b1100;
    wait_grant("post_rst", 1'b0, e, ok);
    if (ok) begin
      count_start("post_rst", 1'b0);
      finish_burst("post_rst", e, 16);
    end
    req = '0;

    // tlast during START is ignored; burst then hangs or times out
    set_len(1, 8);
    push(1, 8);
    req = 4'b0010;
    wait_grant("hang", 1'b0, e, ok);
    if (ok) count_start("hang", 1'b1);
`ifdef RS_SCHED_TIMEOUT_EN
    n = 0;
    while (err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("timeout:cycles", 32'(n), 32'(TO_P));
    check("timeout:done", 32'(done), 0);
    check("timeout:grant", 32'(grant), 0);
    check("timeout:busy_gap", 32'(busy), 1);
    req = '0;
    repeat (GAP) tick();
    check("timeout:idle", 32'(busy), 0);
`else
    n = 0;
    repeat (300) begin
      tick();
      if (err === 1'b1 || done !== '0) n++;
    end
    check("hang:busy", 32'(busy), 1);
    check("hang:grant", 32'(grant), 32'(4'b0010));
    check("hang:no_pulse", 32'(n), 0);
    req = '0;
    #2 rst_n = 1'b0;
    #1;
    check("hang:rst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    tick();
`endif

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
